blake_nonce_scan: RTL and testbench
===================================

Name: blake_nonce_scan

Overview:
Job-level initiator that drives the BLAKE-512 hash core's ena/din interface and consumes its dout/rdy.
- Accepts a 76-byte header template, nonce range and target from the host over a valid/ready handshake.
- Iterates nonces, issuing one ena pulse per 80-byte message, and compares each hash against the target.
- Returns the first winning nonce, or an exhausted or timeout status, on a valid/ready result port.

Parameters:
- TGT_W, 64: number of hash MSBs compared against the target, from dout[511] downward.
- TIMEOUT, 64: maximum cycles to wait for core_rdy after core_ena before declaring an error.

Ports:
- clk  in  1  clock
- rstb  in  1  asynchronous, active-low reset
- job_valid  in  1  host job offer
- job_ready  out  1  high only in IDLE
- job_header  in  608  bytes 0..75 of the message, byte 0 in [607:600]
- job_nonce_start  in  32  first nonce
- job_nonce_end  in  32  last nonce, inclusive
- job_target  in  TGT_W  hit when dout[511 -: TGT_W] < target (unsigned)
- abort  in  1  level; cancels the running job
- core_ena  out  1  one-cycle start pulse to the hash core
- core_din  out  640  {header, nonce}; nonce big-endian in [31:0]
- core_dout  in  512  core hash result
- core_rdy  in  1  core completion pulse
- res_valid  out  1  result available
- res_ready  in  1  host accepts the result
- res_status  out  2  0 = found, 1 = exhausted, 2 = timeout
- res_nonce  out  32  last nonce hashed
- res_hash  out  512  hash of res_nonce
- busy  out  1  high in any state other than IDLE
- hash_count  out  32  hashes completed in the current job

Behaviour:
Reset (async):
- State is IDLE.
- core_ena, res_valid and busy are 0; job_ready is 1.
- core_din, res_status, res_nonce, res_hash and hash_count are 0.

States: IDLE, LOAD, WAIT, REPORT, DRAIN.

IDLE
- On job_valid (job_ready is 1), latch header, start, end and target.
- Set nonce := start and hash_count := 0, then go to LOAD.

LOAD (1 cycle)
- core_din = {header, nonce}; core_ena = 1 for exactly this cycle.
- Clear the timeout counter and go to WAIT.
- core_din stays stable from LOAD until the next LOAD or IDLE.

WAIT
- The timeout counter increments every cycle.
- On core_rdy:
  - hash_count increments (wraps mod 2^32); capture core_dout into res_hash and nonce into res_nonce.
  - If hit: status = 0, go to REPORT.
  - Else if nonce == end: status = 1, go to REPORT.
  - Else nonce := nonce + 1 (mod 2^32) and go to LOAD.
- If the counter reaches TIMEOUT without core_rdy: status = 2, res_hash = 0, go to REPORT.

REPORT
- res_valid = 1; all res_* outputs are held stable until res_ready.
- On res_valid && res_ready, go to IDLE in the next cycle; res_valid drops.
- abort is ignored in REPORT.

abort (LOAD or WAIT)
- In LOAD: core_ena still pulses, then go to DRAIN.
- In WAIT: go to DRAIN. If core_rdy arrives in the same cycle, abort wins and the hash is discarded with no result.

DRAIN
- Wait for core_rdy or timeout, then go to IDLE with no result.
- The core has no cancel input, so a new ena must not overlap an in-flight hash.

Ordering and rates:
- Nonce order: start, start+1, ... up to end, wrapping through 0xFFFFFFFF→0 when start > end.
- start == end produces exactly one hash.
- core_rdy outside WAIT/DRAIN is ignored.
- Throughput: one hash per (core latency + 2) cycles. No second ena is issued before rdy.
- hit compares strictly less-than; hash == target is not a hit.

Decomposition:
- Package blake_scan_pkg holds:
  - the state enum;
  - HDR_BITS = 608 and NONCE_W = 32;
  - status codes ST_FOUND = 0, ST_EXHAUST = 1, ST_TIMEOUT = 2.
- Sub-module blake_target_cmp: combinational, parameter TGT_W, inputs hash[511:0] and target, output hit.

Test Plan:
1. Behavioural core model (rdy 18 cycles after ena); start=0, end=3, target=0 → 4 ena pulses with din[31:0] = 0, 1, 2, 3; res_status=1, res_nonce=3, hash_count=4.
2. Model returns MSBs 0x0000_0000_0000_0001 for nonce 5; start=2, end=10, target=2 → res_status=0, res_nonce=5, hash_count=4; no ena after nonce 5.
3. start=0xFFFFFFFE, end=1 → nonces FFFFFFFE, FFFFFFFF, 0, 1 in that order; status=1.
4. Core never asserts rdy, TIMEOUT=64 → res_status=2 exactly 64 cycles after WAIT entry; job_ready returns after res_ready.
5. abort asserted in WAIT, the same cycle as core_rdy → no res_valid; IDLE after DRAIN; the next job starts cleanly. Also check rstb asserted mid-WAIT → all outputs reset immediately.
6. res_ready held low 10 cycles in REPORT → res_* stable, job_ready=0, no ena; completes on the handshake.

Source files
------------

// File: rtl/blake_scan_pkg.sv
// Shared types and constants for the BLAKE-512 nonce scanner.
// Holds the scanner state encoding, message field widths and result status codes.
package blake_scan_pkg;

    localparam int HDR_BITS = 608;
    localparam int NONCE_W  = 32;

    localparam logic [1:0] ST_FOUND   = 2'd0;
    localparam logic [1:0] ST_EXHAUST = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_REPORT,
        S_DRAIN
    } state_t;

endpackage

// File: rtl/blake_target_cmp.sv
// Difficulty check: hit when the top TGT_W bits of the hash are strictly below the target.
// The target is left-aligned against the full hash, which gives the same ordering as comparing MSBs alone.
module blake_target_cmp #(
    parameter int TGT_W = 64
) (
    input  logic [511:0]     hash,
    input  logic [TGT_W-1:0] target,
    output logic             hit
);

    generate
        if (TGT_W < 512) begin : g_pad
            assign hit = hash < {target, {(512-TGT_W){1'b0}}};
        end else begin : g_full
            assign hit = hash < target;
        end
    endgenerate

endmodule

// File: rtl/blake_nonce_scan.sv
// Job-level nonce scanner: feeds {header, nonce} messages to the BLAKE-512 core one at a time
// and reports the first hash below target, range exhaustion, or a core timeout.
module blake_nonce_scan
    import blake_scan_pkg::*;
#(
    parameter int TGT_W   = 64,
    parameter int TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        rstb,
    input  logic                        job_valid,
    output logic                        job_ready,
    input  logic [HDR_BITS-1:0]         job_header,
    input  logic [NONCE_W-1:0]          job_nonce_start,
    input  logic [NONCE_W-1:0]          job_nonce_end,
    input  logic [TGT_W-1:0]            job_target,
    input  logic                        abort,
    output logic                        core_ena,
    output logic [HDR_BITS+NONCE_W-1:0] core_din,
    input  logic [511:0]                core_dout,
    input  logic                        core_rdy,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [1:0]                  res_status,
    output logic [NONCE_W-1:0]          res_nonce,
    output logic [511:0]                res_hash,
    output logic                        busy,
    output logic [31:0]                 hash_count
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t                state_reg,      state_next;
    logic [HDR_BITS-1:0]   header_reg,     header_next;
    logic [NONCE_W-1:0]    nonce_reg,      nonce_next;
    logic [NONCE_W-1:0]    end_reg,        end_next;
    logic [TGT_W-1:0]      target_reg,     target_next;
    logic [TMO_W-1:0]      tmo_reg,        tmo_next;
    logic [31:0]           cnt_reg,        cnt_next;
    logic [1:0]            status_reg,     status_next;
    logic [NONCE_W-1:0]    res_nonce_reg,  res_nonce_next;
    logic [511:0]          res_hash_reg,   res_hash_next;
    logic                  rdy_seen_reg,   rdy_seen_next;
    logic                  hit;

    blake_target_cmp #(
        .TGT_W (TGT_W)
    ) u_cmp (
        .hash   (core_dout),
        .target (target_reg),
        .hit    (hit)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_reg     <= S_IDLE;
            header_reg    <= '0;
            nonce_reg     <= '0;
            end_reg       <= '0;
            target_reg    <= '0;
            tmo_reg       <= '0;
            cnt_reg       <= '0;
            status_reg    <= ST_FOUND;
            res_nonce_reg <= '0;
            res_hash_reg  <= '0;
            rdy_seen_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            header_reg    <= header_next;
            nonce_reg     <= nonce_next;
            end_reg       <= end_next;
            target_reg    <= target_next;
            tmo_reg       <= tmo_next;
            cnt_reg       <= cnt_next;
            status_reg    <= status_next;
            res_nonce_reg <= res_nonce_next;
            res_hash_reg  <= res_hash_next;
            rdy_seen_reg  <= rdy_seen_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        header_next    = header_reg;
        nonce_next     = nonce_reg;
        end_next       = end_reg;
        target_next    = target_reg;
        tmo_next       = tmo_reg;
        cnt_next       = cnt_reg;
        status_next    = status_reg;
        res_nonce_next = res_nonce_reg;
        res_hash_next  = res_hash_reg;
        rdy_seen_next  = rdy_seen_reg;

        case (state_reg)
            S_IDLE: begin
                if (job_valid) begin
                    header_next = job_header;
                    nonce_next  = job_nonce_start;
                    end_next    = job_nonce_end;
                    target_next = job_target;
                    cnt_next    = '0;
                    state_next  = S_LOAD;
                end
            end
            S_LOAD: begin
                tmo_next      = '0;
                rdy_seen_next = 1'b0;
                state_next    = abort ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                tmo_next = tmo_reg + 1'b1;
                if (abort) begin
                    // A completion in the abort cycle means the core is already idle,
                    // so DRAIN only needs a single cycle.
                    rdy_seen_next = core_rdy;
                    state_next    = S_DRAIN;
                end else if (core_rdy) begin
                    cnt_next       = cnt_reg + 32'd1;
                    res_hash_next  = core_dout;
                    res_nonce_next = nonce_reg;
                    if (hit) begin
                        status_next = ST_FOUND;
                        state_next  = S_REPORT;
                    end else if (nonce_reg == end_reg) begin
                        status_next = ST_EXHAUST;
                        state_next  = S_REPORT;
                    end else begin
                        nonce_next = nonce_reg + 1'b1;
                        state_next = S_LOAD;
                    end
                end else if (tmo_reg >= TMO_LAST) begin
                    status_next    = ST_TIMEOUT;
                    res_hash_next  = '0;
                    res_nonce_next = nonce_reg;
                    state_next     = S_REPORT;
                end
            end
            S_REPORT: begin
                if (res_ready) begin
                    state_next = S_IDLE;
                end
            end
            S_DRAIN: begin
                tmo_next = tmo_reg + 1'b1;
                if (rdy_seen_reg || core_rdy || (tmo_reg >= TMO_LAST)) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign job_ready  = (state_reg == S_IDLE);
    assign busy       = (state_reg != S_IDLE);
    assign core_ena   = (state_reg == S_LOAD);
    assign core_din   = {header_reg, nonce_reg};
    assign res_valid  = (state_reg == S_REPORT);
    assign res_status = status_reg;
    assign res_nonce  = res_nonce_reg;
    assign res_hash   = res_hash_reg;
    assign hash_count = cnt_reg;

endmodule

// File: tb/tb_blake_nonce_scan.sv
// Directed bench for blake_nonce_scan with a behavioural hash core (fixed 18-cycle latency).
// Table-driven jobs plus hand sequences for timeout, abort and mid-job reset.
module tb_blake_nonce_scan;
    import blake_scan_pkg::*;

    localparam int TGT_W   = 64;
    localparam int TIMEOUT = 64;
    localparam int LAT     = 18;

    logic                        clk = 1'b0;
    logic                        rstb = 1'b0;
    logic                        job_valid = 1'b0;
    logic                        job_ready;
    logic [HDR_BITS-1:0]         job_header = '0;
    logic [NONCE_W-1:0]          job_nonce_start = '0;
    logic [NONCE_W-1:0]          job_nonce_end = '0;
    logic [TGT_W-1:0]            job_target = '0;
    logic                        abort = 1'b0;
    logic                        core_ena;
    logic [HDR_BITS+NONCE_W-1:0] core_din;
    logic [511:0]                core_dout = '0;
    logic                        core_rdy = 1'b0;
    logic                        res_valid;
    logic                        res_ready = 1'b0;
    logic [1:0]                  res_status;
    logic [NONCE_W-1:0]          res_nonce;
    logic [511:0]                res_hash;
    logic                        busy;
    logic [31:0]                 hash_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    blake_nonce_scan #(
        .TGT_W   (TGT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk             (clk),
        .rstb            (rstb),
        .job_valid       (job_valid),
        .job_ready       (job_ready),
        .job_header      (job_header),
        .job_nonce_start (job_nonce_start),
        .job_nonce_end   (job_nonce_end),
        .job_target      (job_target),
        .abort           (abort),
        .core_ena        (core_ena),
        .core_din        (core_din),
        .core_dout       (core_dout),
        .core_rdy        (core_rdy),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_status      (res_status),
        .res_nonce       (res_nonce),
        .res_hash        (res_hash),
        .busy            (busy),
        .hash_count      (hash_count)
    );

    // Core model state
    bit           model_on = 1'b0;
    bit           hit_en = 1'b0;
    logic [31:0]  hit_nonce = '0;
    int           cd = 0;
    logic [31:0]  lat_nonce = '0;
    int unsigned  ena_q[$];
    int           overlap_cnt = 0;

    function automatic logic [511:0] hash_of(input logic [31:0] n, input bit he, input logic [31:0] hn);
        logic [63:0] msb;
        msb = (he && n == hn) ? 64'h0000_0000_0000_0001 : {32'h8000_0000, n};
        return {msb, {14{n}}};
    endfunction

    always @(posedge clk) begin
        #1;
        core_rdy = 1'b0;
        if (core_ena) ena_q.push_back(core_din[31:0]);
        if (!model_on) begin
            cd = 0;
        end else begin
            if (cd > 0) begin
                cd = cd - 1;
                if (cd == 0) begin
                    core_rdy  = 1'b1;
                    core_dout = hash_of(lat_nonce, hit_en, hit_nonce);
                end
            end
            if (core_ena) begin
                if (cd > 0) overlap_cnt++;
                cd = LAT;
                lat_nonce = core_din[31:0];
            end
        end
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_job_ready"},  job_ready, 1);
        chk({tag, "_busy"},       busy, 0);
        chk({tag, "_core_ena"},   core_ena, 0);
        chk({tag, "_res_valid"},  res_valid, 0);
        chk({tag, "_core_din"},   core_din, 0);
        chk({tag, "_res_status"}, res_status, 0);
        chk({tag, "_res_nonce"},  res_nonce, 0);
        chk({tag, "_res_hash"},   res_hash, 0);
        chk({tag, "_hash_count"}, hash_count, 0);
    endtask

    task automatic offer_job(input logic [31:0] s, input logic [31:0] e, input logic [63:0] t);
        job_nonce_start = s;
        job_nonce_end   = e;
        job_target      = t;
        job_valid       = 1'b1;
        tick();
        job_valid       = 1'b0;
    endtask

    task automatic handshake(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_valid_drop"}, res_valid, 0);
        chk({tag, "_job_ready"},  job_ready, 1);
        chk({tag, "_busy"},       busy, 0);
    endtask

    typedef struct {
        logic [31:0] s;
        logic [31:0] e;
        logic [63:0] tgt;
        bit          he;
        logic [31:0] hn;
        int          hold;
        logic [1:0]  st;
        logic [31:0] nn;
        logic [31:0] cnt;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] s, input logic [31:0] e, input logic [63:0] tgt,
                                input bit he, input logic [31:0] hn, input int hold,
                                input logic [1:0] st, input logic [31:0] nn, input logic [31:0] cnt);
        vec_t v;
        v.s = s; v.e = e; v.tgt = tgt; v.he = he; v.hn = hn; v.hold = hold;
        v.st = st; v.nn = nn; v.cnt = cnt;
        return v;
    endfunction

    task automatic run_job(input vec_t v, input int id);
        int          n;
        int          ena_before;
        logic [31:0] exp_n;
        logic [511:0] exp_h;
        hit_en    = v.he;
        hit_nonce = v.hn;
        model_on  = 1'b1;
        ena_q.delete();
        chk("offer_job_ready", job_ready, 1);
        offer_job(v.s, v.e, v.tgt);
        n = 0;
        while (!res_valid && n < 3000) begin
            tick();
            n++;
        end
        exp_h = hash_of(v.nn, v.he, v.hn);
        chk("res_valid_seen", res_valid, 1);
        chk("res_status",     res_status, v.st);
        chk("res_nonce",      res_nonce, v.nn);
        chk("res_hash",       res_hash, exp_h);
        chk("hash_count",     hash_count, v.cnt);
        chk("ena_count",      ena_q.size(), v.cnt);
        chk("din_header",     core_din[HDR_BITS+NONCE_W-1:NONCE_W], job_header);
        for (int i = 0; i < ena_q.size(); i++) begin
            exp_n = v.s + 32'(i);
            chk("ena_nonce", ena_q[i], exp_n);
        end
        ena_before = ena_q.size();
        for (int h = 0; h < v.hold; h++) begin
            tick();
            chk("hold_ctrl", {res_valid, job_ready, res_status, res_nonce}, {1'b1, 1'b0, v.st, v.nn});
            chk("hold_hash", res_hash, exp_h);
            chk("hold_no_ena", ena_q.size(), ena_before);
        end
        handshake("job_done");
        $display("job %0d start=%h end=%h target=%h -> status=%0d nonce=%h count=%0d enas=%0d",
                 id, v.s, v.e, v.tgt, res_status, res_nonce, hash_count, ena_q.size());
    endtask

    vec_t vecs[7];

    initial begin
        int n;
        bit saw_valid;

        for (int i = 0; i < 19; i++) job_header[i*32 +: 32] = 32'hC0DE_0000 ^ (32'h1000_0001 * i);

        vecs[0] = mk(32'd0,          32'd3,  64'd0, 0, 32'd0, 0,  ST_EXHAUST, 32'd3,  32'd4);
        vecs[1] = mk(32'd2,          32'd10, 64'd2, 1, 32'd5, 0,  ST_FOUND,   32'd5,  32'd4);
        vecs[2] = mk(32'hFFFF_FFFE,  32'd1,  64'd0, 0, 32'd0, 0,  ST_EXHAUST, 32'd1,  32'd4);
        vecs[3] = mk(32'd7,          32'd7,  64'd0, 0, 32'd0, 0,  ST_EXHAUST, 32'd7,  32'd1);
        vecs[4] = mk(32'd9,          32'd9,  64'd1, 1, 32'd9, 0,  ST_EXHAUST, 32'd9,  32'd1);
        vecs[5] = mk(32'd20,         32'd30, 64'hFFFF_FFFF_FFFF_FFFF, 0, 32'd0, 0, ST_FOUND, 32'd20, 32'd1);
        vecs[6] = mk(32'd0,          32'd1,  64'd0, 0, 32'd0, 10, ST_EXHAUST, 32'd1,  32'd2);

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rstb = 1'b1;
        tick();
        check_reset_outputs("post_reset");

        for (int i = 0; i < 7; i++) run_job(vecs[i], i);

        // Core never answers: timeout exactly TIMEOUT cycles after WAIT entry
        model_on = 1'b0;
        ena_q.delete();
        offer_job(32'd100, 32'd200, 64'd0);
        chk("tmo_load_ena", core_ena, 1);
        n = 0;
        while (!res_valid && n < 200) begin
            tick();
            n++;
        end
        chk("tmo_latency",  n, TIMEOUT + 1);
        chk("tmo_status",   res_status, ST_TIMEOUT);
        chk("tmo_nonce",    res_nonce, 32'd100);
        chk("tmo_hash",     res_hash, 0);
        chk("tmo_count",    hash_count, 0);
        chk("tmo_ena_cnt",  ena_q.size(), 1);
        chk("tmo_job_rdy",  job_ready, 0);
        handshake("tmo");
        $display("job timeout start=00000064 -> status=%0d cycles=%0d", res_status, n);

        // Abort in the same cycle as core_rdy: no result, back to IDLE, next job clean
        model_on = 1'b1;
        hit_en   = 1'b0;
        ena_q.delete();
        offer_job(32'd0, 32'd5, 64'd0);
        repeat (LAT) @(posedge clk);
        #2;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 1);
        saw_valid = 1'b0;
        n = 0;
        while (!job_ready && n < TIMEOUT + 10) begin
            if (res_valid) saw_valid = 1'b1;
            tick();
            n++;
        end
        chk("abort_idle",      job_ready, 1);
        chk("abort_no_result", saw_valid, 0);
        chk("abort_count",     hash_count, 0);
        repeat (5) tick();
        chk("abort_no_ena",    ena_q.size(), 1);
        chk("abort_no_valid",  res_valid, 0);
        $display("job abort -> idle after %0d cycles, result_seen=%0d", n, saw_valid);
        run_job(vecs[0], 10);

        // Asynchronous reset in the middle of WAIT
        ena_q.delete();
        offer_job(32'd0, 32'd3, 64'd0);
        repeat (5) @(posedge clk);
        #2;
        chk("mid_busy", busy, 1);
        rstb = 1'b0;
        model_on = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(posedge clk);
        #1;
        rstb = 1'b1;
        tick();
        check_reset_outputs("mid_release");
        $display("job reset mid-wait -> busy=%0d job_ready=%0d", busy, job_ready);
        run_job(vecs[1], 11);

        chk("no_overlap_ena", overlap_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
